// File: rtl/adc_reset_sequencer.sv
// adc_reset_sequencer
// -------------------
// Runs the ADC083000 reset handshake. The sequence starts at power-up and
// again on a software request. It waits a start delay, issues a one-cycle
// start pulse to the reset generator, and waits for the returned view-reset
// to rise (acknowledge) and then fall (done). Both waits have timeouts and
// the attempt is retried a bounded number of times. After the reset
// completes, a settle period runs before ready is raised. Downstream capture
// logic uses ready and timeout_err as its gates.
//
// Ports
//   base_clk        sole clock, rising edge
//   system_reset    synchronous active-high reset
//   sw_reset_req    single-cycle request to rerun the sequence (READY/FAIL only)
//   adc_view_reset  view-reset from the reset generator (already registered)
//   reset_start     registered one-cycle start request to the reset generator
//   busy            sequence in progress (states 0-4)
//   ready           reset completed and settled
//   timeout_err     sticky, set when the retries are exhausted
//   retry_count     retries used in the current sequence
//   state           current state code, for debug

module adc_reset_sequencer #(
    parameter logic [31:0] START_DELAY   = 32'd3,
    parameter logic [31:0] ACK_TIMEOUT   = 32'd64,
    parameter logic [31:0] SETTLE_CYCLES = 32'd1024,
    parameter logic [3:0]  MAX_RETRIES   = 4'd3
) (
    input  logic       base_clk,
    input  logic       system_reset,
    input  logic       sw_reset_req,
    input  logic       adc_view_reset,
    output logic       reset_start,
    output logic       busy,
    output logic       ready,
    output logic       timeout_err,
    output logic [3:0] retry_count,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_WAIT_DELAY = 3'd0,
        ST_PULSE      = 3'd1,
        ST_WAIT_ACK   = 3'd2,
        ST_WAIT_DONE  = 3'd3,
        ST_SETTLE     = 3'd4,
        ST_READY      = 3'd5,
        ST_FAIL       = 3'd6
    } state_t;

    // A zero-length period behaves as one cycle, so the terminal count never underflows.
    localparam logic [31:0] DELAY_LAST  = (START_DELAY   == 32'd0) ? 32'd0 : START_DELAY   - 32'd1;
    localparam logic [31:0] ACK_LAST    = (ACK_TIMEOUT   == 32'd0) ? 32'd0 : ACK_TIMEOUT   - 32'd1;
    localparam logic [31:0] SETTLE_LAST = (SETTLE_CYCLES == 32'd0) ? 32'd0 : SETTLE_CYCLES - 32'd1;

    state_t      cur_state;
    state_t      nxt_state;
    logic [31:0] counter;
    logic [3:0]  nxt_retry;
    logic        nxt_err;
    logic        timed_out;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path infers a latch.
        nxt_state = cur_state;
        nxt_retry = retry_count;
        nxt_err   = timeout_err;
        timed_out = 1'b0;

        case (cur_state)
            ST_WAIT_DELAY: if (counter == DELAY_LAST) nxt_state = ST_PULSE;
            ST_PULSE:      nxt_state = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                // A valid acknowledge beats a timeout landing in the same cycle.
                if (adc_view_reset)            nxt_state = ST_WAIT_DONE;
                else if (counter == ACK_LAST)  timed_out = 1'b1;
            end
            ST_WAIT_DONE: begin
                if (!adc_view_reset)           nxt_state = ST_SETTLE;
                else if (counter == ACK_LAST)  timed_out = 1'b1;
            end
            ST_SETTLE:     if (counter == SETTLE_LAST) nxt_state = ST_READY;
            ST_READY: begin
                // A software rerun takes priority over an external reset seen on the view line.
                if (sw_reset_req) begin
                    nxt_state = ST_WAIT_DELAY;
                    nxt_retry = 4'd0;
                    nxt_err   = 1'b0;
                end else if (adc_view_reset) begin
                    nxt_state = ST_WAIT_DONE;
                end
            end
            ST_FAIL: begin
                if (sw_reset_req) begin
                    nxt_state = ST_WAIT_DELAY;
                    nxt_retry = 4'd0;
                    nxt_err   = 1'b0;
                end
            end
            default:       nxt_state = ST_WAIT_DELAY;
        endcase

        if (timed_out) begin
            if (retry_count < MAX_RETRIES) begin
                nxt_retry = retry_count + 4'd1;
                nxt_state = ST_WAIT_DELAY;
            end else begin
                nxt_state = ST_FAIL;
                nxt_err   = 1'b1;
            end
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge base_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (system_reset) begin
            cur_state   <= ST_WAIT_DELAY;
            counter     <= 32'd0;
            reset_start <= 1'b0;
            busy        <= 1'b1;
            ready       <= 1'b0;
            timeout_err <= 1'b0;
            retry_count <= 4'd0;
        end else begin
            cur_state   <= nxt_state;
            counter     <= (nxt_state != cur_state) ? 32'd0 : counter + 32'd1;
            reset_start <= (nxt_state == ST_PULSE);
            busy        <= (nxt_state != ST_READY) && (nxt_state != ST_FAIL);
            ready       <= (nxt_state == ST_READY);
            timeout_err <= nxt_err;
            retry_count <= nxt_retry;
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_adc_reset_sequencer.sv
// tb_adc_reset_sequencer
// ----------------------
// dut_a uses short timing (START_DELAY=3, ACK_TIMEOUT=8, SETTLE_CYCLES=16,
// MAX_RETRIES=3). It is compared every cycle against a phase/countdown model
// and also gets directed timing checks. dut_b uses START_DELAY=0 with the
// other parameters at their defaults, and covers the nominal power-up and the
// zero-delay boundary.

module tb_adc_reset_sequencer;

    localparam int A_SD = 3;
    localparam int A_AT = 8;
    localparam int A_SC = 16;
    localparam int A_MR = 3;

    localparam int S_DLY  = 0;
    localparam int S_PUL  = 1;
    localparam int S_ACK  = 2;
    localparam int S_DONE = 3;
    localparam int S_SET  = 4;
    localparam int S_RDY  = 5;
    localparam int S_FAIL = 6;

    logic base_clk = 1'b0;
    always #5 base_clk = ~base_clk;

    logic       a_rst = 1'b1, a_sw = 1'b0, a_view = 1'b0;
    logic       a_start, a_busy, a_ready, a_err;
    logic [3:0] a_retry;
    logic [2:0] a_state;

    logic       b_rst = 1'b1, b_sw = 1'b0, b_view = 1'b0;
    logic       b_start, b_busy, b_ready, b_err;
    logic [3:0] b_retry;
    logic [2:0] b_state;

    adc_reset_sequencer #(
        .START_DELAY   (32'd3),
        .ACK_TIMEOUT   (32'd8),
        .SETTLE_CYCLES (32'd16),
        .MAX_RETRIES   (4'd3)
    ) dut_a (
        .base_clk       (base_clk),
        .system_reset   (a_rst),
        .sw_reset_req   (a_sw),
        .adc_view_reset (a_view),
        .reset_start    (a_start),
        .busy           (a_busy),
        .ready          (a_ready),
        .timeout_err    (a_err),
        .retry_count    (a_retry),
        .state          (a_state)
    );

    adc_reset_sequencer #(
        .START_DELAY (32'd0)
    ) dut_b (
        .base_clk       (base_clk),
        .system_reset   (b_rst),
        .sw_reset_req   (b_sw),
        .adc_view_reset (b_view),
        .reset_start    (b_start),
        .busy           (b_busy),
        .ready          (b_ready),
        .timeout_err    (b_err),
        .retry_count    (b_retry),
        .state          (b_state)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model for dut_a: current phase plus the cycles remaining in it.
    int m_state = 0;
    int m_left  = 0;
    int m_retry = 0;
    bit m_err   = 1'b0;
    bit m_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [10:0] pack(input logic [2:0] s, input logic [3:0] r, input logic e,
                                         input logic rd, input logic b, input logic st);
        return {s, r, e, rd, b, st};
    endfunction

    task automatic m_enter(input int p);
        m_state = p;
        case (p)
            S_DLY:          m_left = A_SD;
            S_ACK, S_DONE:  m_left = A_AT;
            S_SET:          m_left = A_SC;
            default:        m_left = 0;
        endcase
    endtask

    task automatic m_timeout();
        if (m_retry < A_MR) begin
            m_retry++;
            m_enter(S_DLY);
        end else begin
            m_err = 1'b1;
            m_enter(S_FAIL);
        end
    endtask

    task automatic m_step(input bit rst, input bit sw, input bit view);
        if (rst) begin
            m_retry = 0;
            m_err   = 1'b0;
            m_valid = 1'b1;
            m_enter(S_DLY);
            return;
        end
        if (!m_valid) return;
        case (m_state)
            S_DLY: begin
                m_left--;
                if (m_left == 0) m_enter(S_PUL);
            end
            S_PUL: m_enter(S_ACK);
            S_ACK, S_DONE: begin
                if ((m_state == S_ACK) == view) begin
                    m_enter(m_state == S_ACK ? S_DONE : S_SET);
                end else begin
                    m_left--;
                    if (m_left == 0) m_timeout();
                end
            end
            S_SET: begin
                m_left--;
                if (m_left == 0) m_enter(S_RDY);
            end
            S_RDY, S_FAIL: begin
                if (sw) begin
                    m_retry = 0;
                    m_err   = 1'b0;
                    m_enter(S_DLY);
                end else if (m_state == S_RDY && view) begin
                    m_enter(S_DONE);
                end
            end
            default: m_enter(S_DLY);
        endcase
    endtask

    function automatic logic [10:0] m_outs();
        return pack(m_state[2:0], m_retry[3:0], m_err, m_state == S_RDY,
                    m_state < S_RDY, m_state == S_PUL);
    endfunction

    // One clock: capture the inputs dut_a will sample, advance, then compare away from the edge.
    task automatic tick();
        bit rst_s, sw_s, view_s;
        rst_s  = a_rst;
        sw_s   = a_sw;
        view_s = a_view;
        @(posedge base_clk);
        #1;
        cyc++;
        m_step(rst_s, sw_s, view_s);
        if (m_valid)
            check("a_model", pack(a_state, a_retry, a_err, a_ready, a_busy, a_start), m_outs());
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int pulses[$];
    int c, p, s4, st3, rdy, r0, npulse;
    int ack_wait, hold_left;
    bit found, v;

    initial begin
        tick();
        tick();
        check("b_reset_outs", pack(b_state, b_retry, b_err, b_ready, b_busy, b_start), 11'h002);

        // dut_b: START_DELAY=0 acts as 1, so the pulse comes one cycle after release.
        r0 = cyc;
        b_rst = 1'b0;
        tick();
        check("b_sd0_pulse", b_start, 1'b1);
        p = cyc;
        st3 = -1; s4 = -1; rdy = -1; npulse = 0;
        for (int i = 0; i < 1200 && rdy < 0; i++) begin
            b_view = (cyc >= p + 2) && (cyc <= p + 16);
            tick();
            if (b_start) npulse++;
            if (b_state == 3'd3 && st3 < 0) st3 = cyc;
            if (b_state == 3'd4 && s4 < 0)  s4 = cyc;
            if (b_ready && rdy < 0)         rdy = cyc;
        end
        check("b_no_extra_pulse", npulse, 0);
        check("b_ack_to_done", st3 - p, 3);
        check("b_settle_entry", s4 - p, 18);
        check("b_settle_len", rdy - s4, 1024);
        check("b_ready_idle", {b_busy, b_retry}, {1'b0, 4'd0});
        b_rst  = 1'b1;
        b_view = 1'b0;
        tick();

        // dut_a: ack never arrives -> four pulses 3+1+8 apart, then FAIL.
        check("a_reset_outs", pack(a_state, a_retry, a_err, a_ready, a_busy, a_start), 11'h002);
        r0 = cyc;
        a_rst = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (a_start) pulses.push_back(cyc);
            if (a_state == 3'd6) found = 1'b1;
        end
        check("a_fail_reached", found, 1'b1);
        check("a_pulse_count", pulses.size(), 4);
        if (pulses.size() > 0) check("a_first_pulse", pulses[0] - r0, 3);
        for (int i = 1; i < pulses.size(); i++)
            check("a_pulse_spacing", pulses[i] - pulses[i-1], 12);
        check("a_fail_outs", pack(a_state, a_retry, a_err, a_ready, a_busy, a_start),
              pack(3'd6, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 5; i++) tick();
        check("a_fail_absorbing", a_state, 3'd6);

        // Software rerun out of FAIL.
        c = cyc;
        a_sw = 1'b1;
        tick();
        a_sw = 1'b0;
        check("a_sw_clears", {a_state, a_retry, a_err, a_busy}, {3'd0, 4'd0, 1'b0, 1'b1});
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (a_start) found = 1'b1;
        end
        check("a_sw_pulse_seen", found, 1'b1);
        check("a_sw_pulse_delay", cyc - c, 4);

        // View stuck high after the ack: WAIT_DONE times out, one retry, then completes.
        p = cyc;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            a_view = (cyc >= p + 2);
            tick();
            if (a_start) found = 1'b1;
        end
        check("a_stuck_repulse", found, 1'b1);
        check("a_stuck_spacing", cyc - p, 14);
        check("a_stuck_retry", a_retry, 4'd1);
        for (int i = 0; i < 3; i++) tick();
        a_view = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            if (a_ready) found = 1'b1;
        end
        check("a_stuck_ready", found, 1'b1);
        check("a_stuck_retry_kept", a_retry, 4'd1);

        // sw_reset_req during SETTLE is ignored.
        a_sw = 1'b1;
        tick();
        a_sw = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (a_start) found = 1'b1;
        end
        p = cyc;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            a_view = (cyc >= p + 2) && (cyc <= p + 4);
            tick();
            if (a_state == 3'd4) found = 1'b1;
        end
        check("a_settle_entered", found, 1'b1);
        a_view = 1'b0;
        s4 = cyc;
        a_sw = 1'b1;
        tick();
        a_sw = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (a_ready) found = 1'b1;
        end
        check("a_settle_len", cyc - s4, 16);
        check("a_settle_retry", a_retry, 4'd0);

        // External reset in READY: five high cycles on the view line.
        c = cyc;
        a_view = 1'b1;
        tick();
        check("a_glitch_ready", a_ready, 1'b0);
        check("a_glitch_state", a_state, 3'd3);
        for (int i = 0; i < 4; i++) tick();
        a_view = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (a_ready) found = 1'b1;
        end
        check("a_glitch_recover", cyc - c, 22);
        check("a_glitch_retry", a_retry, 4'd0);

        // sw_reset_req and the view line together in READY: the software request wins.
        a_sw = 1'b1;
        a_view = 1'b1;
        tick();
        a_sw = 1'b0;
        a_view = 1'b0;
        check("a_sw_over_view", {a_state, a_ready}, {3'd0, 1'b0});

        // system_reset in the middle of WAIT_ACK.
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (a_start) found = 1'b1;
        end
        tick();
        tick();
        check("a_in_wait_ack", a_state, 3'd2);
        a_rst = 1'b1;
        tick();
        a_rst = 1'b0;
        check("a_midseq_reset", pack(a_state, a_retry, a_err, a_ready, a_busy, a_start), 11'h002);

        // Randomized traffic against the model: a responder that sometimes acks late or
        // holds too long, plus spurious view pulses, software requests and resets.
        ack_wait = 0;
        hold_left = 0;
        for (int i = 0; i < 2500; i++) begin
            if (m_state == S_PUL)
                ack_wait = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(2, 12);
            if (ack_wait > 0) begin
                ack_wait--;
                if (ack_wait == 0) hold_left = $urandom_range(1, 11);
            end
            if (m_state == S_RDY && hold_left == 0 && $urandom_range(0, 29) == 0)
                hold_left = $urandom_range(1, 6);
            v = (hold_left > 0);
            if (v) hold_left--;
            a_view = v;
            a_sw   = ($urandom_range(0, 39) == 0);
            a_rst  = ($urandom_range(0, 499) == 0);
            tick();
        end
        a_view = 1'b0;
        a_sw   = 1'b0;
        a_rst  = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
